// File: rtl/bubble_sort_ctrl.sv
// Bubble-sort controller driving a dual-port element memory: compare, swap, advance.
// Optional BSORT_EARLY_EXIT_EN: finish as soon as a full pass makes no swap.
module bubble_sort_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ld_n_1,
  input  logic [N-1:0]      len_m1,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic [N-1:0]      addr_a,
  output logic [N-1:0]      addr_b,
  output logic              wr_en,
  output logic [DATA_W-1:0] wr_data_a,
  output logic [DATA_W-1:0] wr_data_b,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      pass_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_CMP  = 3'd2,
    S_SWAP = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [N-1:0]      bound_q, bound_d;
  logic [N-1:0]      i_q, i_d;
  logic [N-1:0]      j_q, j_d;
  logic              swapped_q, swapped_d;
  logic [DATA_W-1:0] lat_a_q, lat_a_d;
  logic [DATA_W-1:0] lat_b_q, lat_b_d;

  logic advance;
  logic end_of_pass;
  logic last_pass;
  logic early_exit;

  // Outputs are decoded from registered state only (plus start in IDLE),
  // so an asynchronous reset clears them in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bound_q   <= '0;
      i_q       <= '0;
      j_q       <= '0;
      swapped_q <= 1'b0;
      lat_a_q   <= '0;
      lat_b_q   <= '0;
    end else begin
      state_q   <= state_d;
      bound_q   <= bound_d;
      i_q       <= i_d;
      j_q       <= j_d;
      swapped_q <= swapped_d;
      lat_a_q   <= lat_a_d;
      lat_b_q   <= lat_b_d;
    end
  end

  // Only valid in CMP/SWAP, where bound >= 1 and i <= bound-1, so no wrap.
  assign end_of_pass = (j_q == (bound_q - i_q - N'(1)));
  assign last_pass   = (i_q == (bound_q - N'(1)));

`ifdef BSORT_EARLY_EXIT_EN
  assign early_exit = !(swapped_q || (state_q == S_SWAP));
`else
  assign early_exit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    bound_d   = bound_q;
    i_d       = i_q;
    j_d       = j_q;
    swapped_d = swapped_q;
    lat_a_d   = lat_a_q;
    lat_b_d   = lat_b_q;
    advance   = 1'b0;
    ld_n_1    = 1'b0;
    addr_a    = '0;
    addr_b    = '0;
    wr_en     = 1'b0;
    wr_data_a = '0;
    wr_data_b = '0;
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    pass_cnt  = i_q;

    case (state_q)
      S_IDLE: begin
        ld_n_1 = start;
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        bound_d   = len_m1;
        i_d       = '0;
        j_d       = '0;
        swapped_d = 1'b0;
        state_d   = (len_m1 == '0) ? S_DONE : S_CMP;
      end
      S_CMP: begin
        addr_a = j_q;
        addr_b = j_q + N'(1);
        // Strict compare keeps equal elements in place.
        if (rd_data_a > rd_data_b) begin
          lat_a_d = rd_data_a;
          lat_b_d = rd_data_b;
          state_d = S_SWAP;
        end else begin
          advance = 1'b1;
        end
      end
      S_SWAP: begin
        addr_a    = j_q;
        addr_b    = j_q + N'(1);
        wr_en     = 1'b1;
        wr_data_a = lat_b_q;
        wr_data_b = lat_a_q;
        swapped_d = 1'b1;
        advance   = 1'b1;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (!end_of_pass) begin
        j_d     = j_q + N'(1);
        state_d = S_CMP;
      end else if (last_pass || early_exit) begin
        state_d = S_DONE;
      end else begin
        i_d       = i_q + N'(1);
        j_d       = '0;
        swapped_d = 1'b0;
        state_d   = S_CMP;
      end
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl: vector table of sorts plus reset and busy-start sequences.
module tb_bubble_sort_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned NW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ld_n_1;
  logic [NW-1:0] len_m1;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic [NW-1:0] addr_a, addr_b;
  logic          wr_en;
  logic [DW-1:0] wr_data_a, wr_data_b;
  logic          busy, done;
  logic [NW-1:0] pass_cnt;

  logic [DW-1:0] mem [0:15];
  logic          load_req;
  logic [63:0]   load_val;

  int checks = 0;
  int errors = 0;
  int viol   = 0;

  bubble_sort_ctrl #(.DATA_W(DW), .N(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .ld_n_1(ld_n_1), .len_m1(len_m1),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .addr_a(addr_a), .addr_b(addr_b),
    .wr_en(wr_en), .wr_data_a(wr_data_a), .wr_data_b(wr_data_b),
    .busy(busy), .done(done), .pass_cnt(pass_cnt)
  );

  always #5 clk = ~clk;

  assign rd_data_a = mem[addr_a[3:0]];
  assign rd_data_b = mem[addr_b[3:0]];

  always @(posedge clk) begin
    if (load_req) begin
      for (int k = 0; k < 16; k++)
        mem[k] <= (k < 4) ? load_val[16*k +: 16] : 16'h0;
    end else if (wr_en) begin
      mem[addr_a[3:0]] <= wr_data_a;
      mem[addr_b[3:0]] <= wr_data_b;
    end
  end

  // Per-cycle invariants: idle outputs quiet, writes only while busy, addr_b = addr_a + 1 on writes.
  always @(negedge clk) begin
    if (!busy && (wr_en || done || addr_a != '0 || addr_b != '0 ||
                  wr_data_a != '0 || wr_data_b != '0)) viol++;
    if (busy && ld_n_1) viol++;
    if (wr_en && addr_b != addr_a + NW'(1)) viol++;
  end

  typedef struct packed {
    logic [63:0] init_mem;
    logic [63:0] exp_mem;
    int          len;
    int          writes;
    int          lat;
    int          pcnt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic load_mem(input logic [63:0] v);
    @(negedge clk);
    load_val = v;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  function automatic logic [63:0] mem_img();
    return {mem[3], mem[2], mem[1], mem[0]};
  endfunction

  // Issue one start and follow the sort to completion; lat = cycles from start edge to done.
  task automatic run_sort(input int len, input bit hold, output int lat, output int writes,
                          output int lds, output int dones, output int pcnt);
    int cyc;
    lat = -1; writes = 0; lds = 0; dones = 0; pcnt = -1; cyc = 0;
    len_m1 = NW'(len);
    @(negedge clk);
    start = 1'b1;
    #1;
    if (ld_n_1) lds++;
    while (cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = hold;
      if (ld_n_1) lds++;
      if (wr_en) writes++;
      if (done) begin
        dones++;
        lat  = cyc;
        pcnt = int'(pass_cnt);
        break;
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    if (done) dones++;
    if (ld_n_1) lds++;
  endtask

  initial begin
    int lat, writes, lds, dones, pcnt, wcnt;

    vecs[0] = '{init_mem: {16'd9, 16'd2, 16'd1, 16'd3}, exp_mem: {16'd9, 16'd3, 16'd2, 16'd1},
                len: 2, writes: 2, lat: 7, pcnt: 1};
    vecs[1] = '{init_mem: {16'd0, 16'd0, 16'd8, 16'd7}, exp_mem: {16'd0, 16'd0, 16'd8, 16'd7},
                len: 0, writes: 0, lat: 2, pcnt: 0};
`ifdef BSORT_EARLY_EXIT_EN
    vecs[2] = '{init_mem: {16'd4, 16'd3, 16'd2, 16'd1}, exp_mem: {16'd4, 16'd3, 16'd2, 16'd1},
                len: 3, writes: 0, lat: 5, pcnt: 0};
    vecs[5] = '{init_mem: {16'd4, 16'd3, 16'd1, 16'd2}, exp_mem: {16'd4, 16'd3, 16'd2, 16'd1},
                len: 3, writes: 1, lat: 8, pcnt: 1};
`else
    vecs[2] = '{init_mem: {16'd4, 16'd3, 16'd2, 16'd1}, exp_mem: {16'd4, 16'd3, 16'd2, 16'd1},
                len: 3, writes: 0, lat: 8, pcnt: 2};
    vecs[5] = '{init_mem: {16'd4, 16'd3, 16'd1, 16'd2}, exp_mem: {16'd4, 16'd3, 16'd2, 16'd1},
                len: 3, writes: 1, lat: 9, pcnt: 2};
`endif
    vecs[3] = '{init_mem: {16'd0, 16'd1, 16'd5, 16'd5}, exp_mem: {16'd0, 16'd5, 16'd5, 16'd1},
                len: 2, writes: 2, lat: 7, pcnt: 1};
    vecs[4] = '{init_mem: {16'd1, 16'd2, 16'd3, 16'd4}, exp_mem: {16'd4, 16'd3, 16'd2, 16'd1},
                len: 3, writes: 6, lat: 14, pcnt: 2};
    vecs[6] = '{init_mem: {16'd0, 16'd0, 16'h0001, 16'hFFFF}, exp_mem: {16'd0, 16'd0, 16'hFFFF, 16'h0001},
                len: 1, writes: 1, lat: 4, pcnt: 0};

    rst = 1'b1; start = 1'b0; len_m1 = '0; load_req = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_outs", {wr_en, done, ld_n_1, addr_a, addr_b, pass_cnt}, 64'd0);
    rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      load_mem(vecs[v].init_mem);
      run_sort(vecs[v].len, 1'b0, lat, writes, lds, dones, pcnt);
      chk($sformatf("v%0d_mem", v),    mem_img(),    vecs[v].exp_mem);
      chk($sformatf("v%0d_writes", v), 64'(writes),  64'(vecs[v].writes));
      chk($sformatf("v%0d_latency", v), 64'(lat),    64'(vecs[v].lat));
      chk($sformatf("v%0d_pass_cnt", v), 64'(pcnt), 64'(vecs[v].pcnt));
      chk($sformatf("v%0d_done_pulses", v), 64'(dones), 64'd1);
      chk($sformatf("v%0d_ld_pulses", v), 64'(lds), 64'd1);
    end

    // start held high while busy must not disturb the sort
    for (int v = 0; v < 5; v += 4) begin
      load_mem(vecs[v].init_mem);
      run_sort(vecs[v].len, 1'b1, lat, writes, lds, dones, pcnt);
      chk($sformatf("busy_start_v%0d_mem", v), mem_img(), vecs[v].exp_mem);
      chk($sformatf("busy_start_v%0d_latency", v), 64'(lat), 64'(vecs[v].lat));
      chk($sformatf("busy_start_v%0d_ld", v), 64'(lds), 64'd1);
      chk($sformatf("busy_start_v%0d_done", v), 64'(dones), 64'd1);
    end

    // Asynchronous reset in the middle of the second SWAP cycle
    load_mem(vecs[4].init_mem);
    len_m1 = 16'd3;
    @(negedge clk);
    start = 1'b1;
    wcnt = 0;
    for (int c = 0; c < 100 && wcnt < 2; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (wr_en) wcnt++;
    end
    chk("rst_reached_swap2", 64'(wcnt), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_midswap_outs", {wr_en, busy, done}, 64'd0);
    chk("rst_midswap_addr", {addr_a, addr_b, pass_cnt}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    load_mem(vecs[4].init_mem);
    run_sort(3, 1'b0, lat, writes, lds, dones, pcnt);
    chk("post_rst_mem", mem_img(), vecs[4].exp_mem);
    chk("post_rst_writes", 64'(writes), 64'd6);
    chk("post_rst_latency", 64'(lat), 64'd14);

    // First edge after release accepts start
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_sort(0, 1'b0, lat, writes, lds, dones, pcnt);
    chk("first_edge_start_latency", 64'(lat), 64'd2);

    chk("cycle_invariants", 64'(viol), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
